// File: rtl/alu_bus_arbiter_if.sv
// Operand bus between two requesters, the arbiter and the ALU.
// master = requesters/ALU side, slave = arbiter side.
interface alu_bus_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             grant0;
  logic             grant1;
  logic             select;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       count0;
  logic [7:0]       count1;

  modport master (
    output req0, data0, req1, data1, out_ready,
    input  grant0, grant1, select, out_data, out_valid, count0, count1
  );

  modport slave (
    input  req0, data0, req1, data1, out_ready,
    output grant0, grant1, select, out_data, out_valid, count0, count1
  );
endinterface

// File: rtl/alu_bus_arbiter.sv
// Two-requester round-robin arbiter holding one operand for the ALU,
// with back-to-back transfer on accept and per-requester transfer counters.
module alu_bus_arbiter #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           reset,
  alu_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             grant0_q, grant0_d;
  logic             grant1_q, grant1_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [7:0]       count0_q, count0_d;
  logic [7:0]       count1_q, count1_d;
  logic             accept, arb, pick;

  // last_q resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      grant0_q   <= 1'b0;
      grant1_q   <= 1'b0;
      out_data_q <= '0;
      count0_q   <= 8'd0;
      count1_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      grant0_q   <= grant0_d;
      grant1_q   <= grant1_d;
      out_data_q <= out_data_d;
      count0_q   <= count0_d;
      count1_q   <= count1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    grant0_d   = 1'b0;
    grant1_d   = 1'b0;
    out_data_d = out_data_q;
    count0_d   = count0_q;
    count1_d   = count1_q;

    accept = (state_q != IDLE) && bus.out_ready;
    arb    = (state_q == IDLE) || accept;
    // With both requesting, the one not granted last wins; otherwise the sole requester.
    pick   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    if (accept) begin
      if (state_q == BUSY0) count0_d = count0_q + 8'd1;
      else                  count1_d = count1_q + 8'd1;
    end

    if (arb) begin
      if (bus.req0 || bus.req1) begin
        state_d    = pick ? BUSY1 : BUSY0;
        out_data_d = pick ? bus.data1 : bus.data0;
        sel_d      = pick;
        last_d     = pick;
        grant0_d   = ~pick;
        grant1_d   = pick;
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign bus.out_valid = (state_q != IDLE);
  assign bus.select    = sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.grant0    = grant0_q;
  assign bus.grant1    = grant1_q;
  assign bus.count0    = count0_q;
  assign bus.count1    = count1_q;

endmodule

// File: doc/alu_bus_arbiter.md
ALU_BUS_ARBITER -- requirements
Module: alu_bus_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand data width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req0  input  1  requester 0 has an operand to transfer.
REQ-005 SHALL have port data0  input  WIDTH  requester 0 operand, valid while req0=1.
REQ-006 SHALL have port req1  input  1  requester 1 has an operand to transfer.
REQ-007 SHALL have port data1  input  WIDTH  requester 1 operand, valid while req1=1.
REQ-008 SHALL have port grant0  output  1  one-cycle pulse: data0 captured this edge.
REQ-009 SHALL have port grant1  output  1  one-cycle pulse: data1 captured this edge.
REQ-010 SHALL have port select  output  1  2:1 mux select: 0 = requester 0 owns the output, 1 = requester 1.
REQ-011 SHALL have port out_data  output  WIDTH  captured operand presented to the ALU.
REQ-012 SHALL have port out_valid  output  1  out_data holds an unconsumed operand.
REQ-013 SHALL have port out_ready  input  1  ALU consumes out_data at this edge when out_valid=1.
REQ-014 SHALL have port count0  output  8  requester 0 completed-transfer count.
REQ-015 SHALL have port count1  output  8  requester 1 completed-transfer count.

Function
REQ-016 SHALL implement states IDLE, BUSY0, BUSY1; BUSYn means requester n's operand is held in out_data.
REQ-017 SHALL assert out_valid=1 exactly in BUSY0/BUSY1, with select=0 in BUSY0 and select=1 in BUSY1; select SHALL hold its last value in IDLE.
REQ-018 SHALL "arbitrate" at an edge when the state is IDLE, or when the state is BUSYn with out_valid=1 and out_ready=1 (accept).
REQ-019 SHALL, when arbitrating with only reqN=1, capture dataN into out_data, pulse grantN for the following cycle, and enter BUSYN.
REQ-020 SHALL, when arbitrating with req0=1 and req1=1, grant the requester not granted most recently (round-robin via a 1-bit last register updated on every grant).
REQ-021 SHALL, when arbitrating with no request, go to IDLE and keep out_data unchanged.
REQ-022 SHALL give latency 1: a request sampled at edge N yields out_valid=1 and out_data=dataN after edge N.
REQ-023 SHALL support back-to-back transfers: an accept edge with a pending request SHALL grant and capture at that same edge, leaving out_valid continuously high.
REQ-024 SHALL hold out_data, select and state stable while out_valid=1 and out_ready=0.
REQ-025 SHALL never assert grant0 and grant1 in the same cycle, and SHALL ignore reqN while not arbitrating.
REQ-026 SHALL treat reqN still high in the cycle after grantN as a new request.
REQ-027 SHALL increment countN by 1 at each accept edge in BUSYN, wrapping 255 -> 0.
REQ-028 SHALL ignore out_ready while out_valid=0.

Reset
REQ-029 SHALL, on reset=1 asynchronously and independent of clk, force state IDLE, out_valid=0, grant0=0, grant1=0, select=0, out_data=0, count0=0, count1=0, last=1 (requester 0 wins the first contention).
REQ-030 SHALL discard any held operand when reset asserts mid-transfer, with no count increment.
REQ-031 SHALL begin arbitrating at the first rising edge after reset deasserts.

Verification
REQ-032 Single request: req0=1, data0=8'hA5, out_ready=1 -> grant0 pulses one cycle, out_data=8'hA5, select=0, out_valid=1, count0 becomes 1 on the next edge.
REQ-033 Contention: req0=req1=1 held, data0=8'h11, data1=8'h22, out_ready=1 -> out_data sequence 11,22,11,22 on consecutive cycles, select toggling 0,1,0,1, out_valid never dropping.
REQ-034 Backpressure: BUSY1 with out_data=8'h3C, out_ready=0 for 5 cycles while req0=1 -> out_data, select=1 and out_valid=1 stable, no grant0 until the accept edge.
REQ-035 Wrap: 256 accepted transfers from requester 1 -> count1 returns to 0, count0 unchanged.
REQ-036 Reset mid-operation: assert reset between edges in BUSY0 -> out_valid=0, counts=0 immediately; then req0=req1=1 -> requester 0 granted first.
